// File: rtl/noc_link_arbiter.sv
// Round-robin, packet-locked arbiter sharing one NoC output link among NUM_IN sources.
// A source granted on a head flit owns the link until its tail; the output stage is registered.
module noc_link_arbiter #(
  parameter int NUM_IN          = 4,
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int FLIT_TYPE_WIDTH = 2,
  parameter int FLIT_WIDTH      = FLIT_DATA_WIDTH + FLIT_TYPE_WIDTH,
  localparam int GW             = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_IN*FLIT_WIDTH-1:0] in_flit,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [GW-1:0]                grant_id,
  output logic                         locked,
  output logic                         proto_err
);

  localparam logic [FLIT_TYPE_WIDTH-1:0] T_BODY   = FLIT_TYPE_WIDTH'(2'b00);
  localparam logic [FLIT_TYPE_WIDTH-1:0] T_HEAD   = FLIT_TYPE_WIDTH'(2'b01);
  localparam logic [FLIT_TYPE_WIDTH-1:0] T_TAIL   = FLIT_TYPE_WIDTH'(2'b10);
  localparam logic [FLIT_TYPE_WIDTH-1:0] T_SINGLE = FLIT_TYPE_WIDTH'(2'b11);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [GW-1:0]              r_rr_ptr;
  logic [GW-1:0]              r_grant;
  logic                       r_proto_err;
  logic [FLIT_WIDTH-1:0]      r_out_flit;
  logic                       r_out_valid;

  logic [FLIT_WIDTH-1:0]      w_flits [NUM_IN];
  logic [FLIT_TYPE_WIDTH-1:0] w_type  [NUM_IN];
  logic [NUM_IN-1:0]          w_elig;
  logic [NUM_IN-1:0]          w_bad;
  logic                       w_any;
  logic [GW-1:0]              w_winner;
  logic [GW-1:0]              w_sel;
  logic                       w_load;
  logic                       w_xfer;
  logic                       w_proto;
  logic [FLIT_WIDTH-1:0]      w_sel_flit;
  logic [FLIT_TYPE_WIDTH-1:0] w_sel_type;

  // Per-source decode: a body/tail from anyone but the current owner is a violation.
  always_comb begin
    w_elig = '0;
    w_bad  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_flits[i] = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
      w_type[i]  = w_flits[i][FLIT_WIDTH-1 -: FLIT_TYPE_WIDTH];
      w_elig[i]  = in_valid[i] && (w_type[i] == T_HEAD || w_type[i] == T_SINGLE);
      w_bad[i]   = in_valid[i] && (w_type[i] == T_BODY || w_type[i] == T_TAIL) &&
                   !(r_state == S_LOCKED && GW'(i) == r_grant);
    end
  end

  // Round-robin scan starting just after the last owner.
  always_comb begin
    int idx;
    w_any    = 1'b0;
    w_winner = r_rr_ptr;
    idx      = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_IN;
      if (!w_any && w_elig[GW'(idx)]) begin
        w_any    = 1'b1;
        w_winner = GW'(idx);
      end
    end
  end

  assign w_load     = !r_out_valid || out_ready;
  assign w_sel      = (r_state == S_LOCKED) ? r_grant : w_winner;
  assign w_sel_flit = w_flits[w_sel];
  assign w_sel_type = w_type[w_sel];
  assign w_xfer     = |(in_valid & in_ready);
  assign w_proto    = (|w_bad) || (r_state == S_LOCKED && in_valid[r_grant] &&
                      (w_type[r_grant] == T_HEAD || w_type[r_grant] == T_SINGLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // An owner's stray head/single is forwarded but never ends the packet.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_xfer && w_sel_type == T_HEAD) w_state_nxt = S_LOCKED;
      S_LOCKED: if (w_xfer && w_sel_type == T_TAIL) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (rst && w_load) begin
      if (r_state == S_LOCKED) in_ready[r_grant]  = 1'b1;
      else if (w_any)          in_ready[w_winner] = 1'b1;
    end
    locked    = (r_state == S_LOCKED);
    grant_id  = r_grant;
    proto_err = r_proto_err;
    out_flit  = r_out_flit;
    out_valid = r_out_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= GW'(NUM_IN - 1);
      r_grant     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (r_state == S_IDLE) begin
          r_grant <= w_winner;
          if (w_sel_type == T_SINGLE) r_rr_ptr <= w_winner;
        end else if (w_sel_type == T_TAIL) begin
          r_rr_ptr <= r_grant;
        end
      end
      if (w_proto) r_proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_xfer) begin
      r_out_flit  <= w_sel_flit;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_link_arbiter.sv
// Scoreboard bench for noc_link_arbiter: directed packet streams per source,
// expected link flits queued in order and checked by a concurrent monitor.
module tb_noc_link_arbiter;
  localparam int N  = 4;
  localparam int FW = 34;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*FW-1:0] in_flit;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [FW-1:0]   out_flit;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            locked;
  logic            proto_err;

  always #5 clk = ~clk;

  noc_link_arbiter #(.NUM_IN(N), .FLIT_DATA_WIDTH(32), .FLIT_TYPE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .locked(locked), .proto_err(proto_err)
  );

  logic [FW-1:0] sb [$];
  int            n_chk  = 0;
  int            n_pass = 0;
  logic [FW-1:0] src_mem [N][8];
  int            src_len [N];
  int            src_pos [N];

  function automatic logic [FW-1:0] fl(input logic [1:0] t, input logic [31:0] d);
    return {t, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic clr_src();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  task automatic push_src(input int s, input logic [FW-1:0] f);
    src_mem[s][src_len[s]] = f;
    src_len[s]++;
  endtask

  task automatic present();
    for (int i = 0; i < N; i++) begin
      if (src_pos[i] < src_len[i]) begin
        in_valid[i]          = 1'b1;
        in_flit[i*FW +: FW]  = src_mem[i][src_pos[i]];
      end else begin
        in_valid[i]          = 1'b0;
        in_flit[i*FW +: FW]  = '0;
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    present();
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) src_pos[i]++;
    present();
  endtask

  task automatic drain();
    clr_src();
    cycle();
    cycle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_out: got 0x%0h, want no flit", out_flit);
          end else begin
            chk("out_flit", 64'(out_flit), 64'(sb.pop_front()));
          end
        end
      end
    join_none

    rst = 1'b0; out_ready = 1'b1; in_valid = '0; in_flit = '0;
    clr_src();

    // Reset state, then a single flit from source 0.
    push_src(0, 34'h3_0000_0001);
    present();
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_flit",  64'(out_flit),  64'd0);
    chk("rst_locked",    64'(locked),    64'd0);
    chk("rst_grant",     64'(grant_id),  64'd0);
    chk("rst_proto",     64'(proto_err), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("t1_in_ready", 64'(in_ready), 64'h1);
    sb.push_back(34'h3_0000_0001);
    cycle();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_locked",    64'(locked),    64'd0);
    chk("t1_grant",     64'(grant_id),  64'd0);
    drain();

    // Two simultaneous 3-flit packets: source 1 then source 2, no bubbles.
    for (int f = 0; f < 3; f++) begin
      logic [1:0] t;
      t = (f == 0) ? 2'b01 : (f == 1) ? 2'b00 : 2'b10;
      push_src(1, fl(t, 32'h1100_0000 + 32'(f)));
      push_src(2, fl(t, 32'h2200_0000 + 32'(f)));
    end
    for (int f = 0; f < 3; f++) sb.push_back(src_mem[1][f]);
    for (int f = 0; f < 3; f++) sb.push_back(src_mem[2][f]);
    cycle();
    chk("t2_locked_s1", 64'(locked),   64'd1);
    chk("t2_grant_s1",  64'(grant_id), 64'd1);
    cycle(); cycle(); cycle();
    chk("t2_locked_s2", 64'(locked),   64'd1);
    chk("t2_grant_s2",  64'(grant_id), 64'd2);
    cycle(); cycle();
    chk("t2_s1_done", 64'(src_pos[1]), 64'd3);
    chk("t2_s2_done", 64'(src_pos[2]), 64'd3);
    chk("t2_unlocked", 64'(locked), 64'd0);
    drain();

    // Source 3 single first so that the rotation then starts at source 0.
    push_src(3, fl(2'b11, 32'hA000_0033));
    sb.push_back(fl(2'b11, 32'hA000_0033));
    cycle();
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < N; s++) begin
        push_src(s, fl(2'b11, 32'hA000_0000 | 32'(r << 4) | 32'(s)));
        sb.push_back(fl(2'b11, 32'hA000_0000 | 32'(r << 4) | 32'(s)));
      end
    for (int c = 0; c < 8; c++) cycle();
    for (int s = 0; s < N; s++) chk("t3_src_done", 64'(src_pos[s]), 64'(src_len[s]));
    chk("t3_unlocked", 64'(locked), 64'd0);
    drain();

    // Backpressure for three cycles while a body flit sits in the output register.
    push_src(0, fl(2'b01, 32'h4400_0000));
    push_src(0, fl(2'b00, 32'h4400_0001));
    push_src(0, fl(2'b00, 32'h4400_0002));
    push_src(0, fl(2'b10, 32'h4400_0003));
    for (int f = 0; f < 4; f++) sb.push_back(src_mem[0][f]);
    cycle(); cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_stall_in_ready",  64'(in_ready),  64'd0);
      chk("t4_stall_out_valid", 64'(out_valid), 64'd1);
      chk("t4_stall_out_flit",  64'(out_flit),  64'(fl(2'b00, 32'h4400_0001)));
      cycle();
    end
    out_ready = 1'b1;
    cycle(); cycle();
    chk("t4_src_done", 64'(src_pos[0]), 64'd4);
    drain();

    // Source 3 presents a body while source 1 owns the link.
    chk("t5_proto_before", 64'(proto_err), 64'd0);
    push_src(1, fl(2'b01, 32'h5500_0000));
    push_src(1, fl(2'b00, 32'h5500_0001));
    push_src(1, fl(2'b10, 32'h5500_0002));
    push_src(3, fl(2'b00, 32'h5300_0000));
    for (int f = 0; f < 3; f++) sb.push_back(src_mem[1][f]);
    cycle();
    #1;
    chk("t5_locked",   64'(locked),    64'd1);
    chk("t5_grant",    64'(grant_id),  64'd1);
    chk("t5_proto",    64'(proto_err), 64'd1);
    chk("t5_in_ready", 64'(in_ready),  64'h2);
    cycle(); cycle();
    chk("t5_s1_done",  64'(src_pos[1]), 64'd3);
    chk("t5_unlocked", 64'(locked),     64'd0);
    cycle();
    chk("t5_s3_never", 64'(src_pos[3]), 64'd0);
    drain();

    // Reset in the middle of a packet from source 2.
    push_src(2, fl(2'b01, 32'h6600_0000));
    push_src(2, fl(2'b00, 32'h6600_0001));
    push_src(2, fl(2'b10, 32'h6600_0002));
    sb.push_back(src_mem[2][0]);
    cycle(); cycle();
    rst = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_out_flit",  64'(out_flit),  64'd0);
    chk("t6_locked",    64'(locked),    64'd0);
    chk("t6_grant",     64'(grant_id),  64'd0);
    chk("t6_proto",     64'(proto_err), 64'd0);
    clr_src();
    push_src(0, fl(2'b11, 32'h7000_0000));
    push_src(1, fl(2'b11, 32'h7000_0001));
    push_src(3, fl(2'b11, 32'h7000_0003));
    present();
    #1;
    chk("t6_in_ready_rst", 64'(in_ready), 64'd0);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk("t6_first_prio", 64'(in_ready), 64'h1);
    sb.push_back(src_mem[0][0]);
    sb.push_back(src_mem[1][0]);
    sb.push_back(src_mem[3][0]);
    cycle(); cycle(); cycle();
    chk("t6_s0_done", 64'(src_pos[0]), 64'd1);
    chk("t6_s3_done", 64'(src_pos[3]), 64'd1);
    drain();
    chk("t6_proto_after", 64'(proto_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/noc_link_arbiter.md
# noc_link_arbiter

Round-robin, packet-locked arbiter sharing one NoC output link among `NUM_IN` packetizer sources. Each source presents flits with a valid/ready handshake. A source granted on a head flit keeps the link until its tail flit, so packets never interleave. A registered output stage drives the router input port. One flit/cycle sustained throughput, one cycle input-to-output latency.

## Interface
- `NUM_IN`, 4: number of requesting sources (2..8).
- `FLIT_DATA_WIDTH`, 32: flit payload width.
- `FLIT_TYPE_WIDTH`, 2: flit type field width; type occupies the flit MSBs.
- `FLIT_WIDTH`, `FLIT_DATA_WIDTH+FLIT_TYPE_WIDTH`: full flit width.
- Type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_flit`  in  `NUM_IN*FLIT_WIDTH`  source i flit at bits `[i*FLIT_WIDTH +: FLIT_WIDTH]`.
- `in_valid`  in  `NUM_IN`  source i flit valid.
- `in_ready`  out  `NUM_IN`  source i flit accepted this cycle (combinational).
- `out_flit`  out  `FLIT_WIDTH`  registered link flit.
- `out_valid`  out  1  registered link valid.
- `out_ready`  in  1  link/router can accept.
- `grant_id`  out  `$clog2(NUM_IN)`  current or last owner index.
- `locked`  out  1  a packet is in progress (state LOCKED).
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
- A transfer occurs on input i when `in_valid[i] && in_ready[i]`. It occurs on the output when `out_valid && out_ready`.
- `load = !out_valid || out_ready`. Input flits are accepted only when `load` = 1.
- State IDLE:
  - Eligible sources have valid with type head or single.
  - Pick the first eligible source scanning from `rr_ptr+1` upward, wrapping modulo `NUM_IN`. Assert only its `in_ready` when `load` = 1.
  - On transfer of a head: go to LOCKED, `grant_id` = winner.
  - On transfer of a single: stay IDLE, `rr_ptr` = winner, `grant_id` = winner.
- State LOCKED:
  - Only `in_ready[grant_id]` can assert, equal to `load`. All others are 0.
  - On a tail transfer: go to IDLE, `rr_ptr` = `grant_id`.
  - Body transfers stay LOCKED.
- Protocol errors (set `proto_err`, cleared only by reset):
  - Owner presents a head or single while LOCKED. The flit is still forwarded and the state stays LOCKED.
  - Any source presents valid body or tail while not the locked owner. That flit is never accepted.
- Output register:
  - On an accepted input, `out_flit` ← the flit and `out_valid` ← 1.
  - Otherwise, if `out_ready`, `out_valid` ← 0 and `out_flit` holds.
- Flit contents pass through unmodified.

## Timing
- Reset (`rst` = 0, immediate):
  - `out_valid` 0, `out_flit` 0, `locked` 0, `grant_id` 0, `proto_err` 0.
  - State IDLE, `rr_ptr` = `NUM_IN-1` (source 0 has first priority).
  - `in_ready` is all 0 while reset is asserted.
- Latency: a flit accepted at edge k appears on `out_flit`/`out_valid` after edge k.
- Back-to-back streaming: no bubbles when `out_ready` stays 1, including a new packet's head in the cycle after the previous tail.
- Backpressure: if `out_valid && !out_ready`, then `in_ready` is all 0 and the output holds stable.
- A source lowering valid mid-packet keeps the lock. Other sources wait indefinitely; there is no timeout.
- Fairness: after owner j releases, the next grant goes to the first requester in j+1, j+2, … order. This gives a worst-case wait of `NUM_IN-1` packets.
- Reset mid-packet: the lock is dropped and the output is invalidated. The partial packet is not completed.
- `in_ready` depends combinationally on `in_valid`, `in_flit` type, state and `out_ready`. It does not depend on `in_flit` data.

## Test plan
- Reset, then source 0 sends single 0x3_0000_0001 with `out_ready` = 1. Expect `in_ready[0]` = 1 that cycle, `out_flit` = 0x3_0000_0001 and `out_valid` = 1 next cycle, `locked` = 0, `grant_id` = 0.
- Sources 1 and 2 each present a 3-flit packet (head 0x1_…, body 0x0_…, tail 0x2_…) simultaneously. Expect source 1's three flits contiguous, then source 2's, with no interleave and no idle cycle between them. `locked` = 1 during each packet.
- All four sources request repeatedly with single flits. Expect grant order 0,1,2,3,0,… with one flit per cycle.
- Hold `out_ready` = 0 for 3 cycles during a body flit. Expect `out_flit` and `out_valid` stable, `in_ready` all 0, and no flit lost or duplicated after release.
- While source 1 is LOCKED, source 3 presents a body flit. Expect source 3 is never accepted, `proto_err` = 1, and source 1's packet completes normally.
- Assert `rst` = 0 mid-packet. Expect all outputs at reset values immediately. After release, source 0 gets first priority.
